// File: rtl/multiport_fifo_if.sv
// ---------------------------------------------------------------------------
// multiport_fifo_if
// Purpose : Bundles the producer, consumer and flush signals of a
//           multiport_fifo into one interface.
// Parameters mirror the FIFO: ENTRY_WIDTH, N_ENTRIES, N_ENQ, N_DEQ.
// Signals :
//   flush     - synchronous discard of all FIFO contents
//   enq_valid - per enqueue lane valid, lane 0 oldest
//   enq_ready - per enqueue lane ready (free slots > lane index)
//   enq_data  - enqueue lane data, lane i at [i*ENTRY_WIDTH +: ENTRY_WIDTH]
//   deq_ready - per dequeue lane consumer ready, lane 0 oldest
//   deq_valid - per dequeue lane valid (occupied slots > lane index)
//   deq_data  - dequeue lane data, lane i = entry at head+i
//   count     - occupied entries
//   free_cnt  - free entries
// Modports: master = pipeline side driving the FIFO, slave = the FIFO itself.
// ---------------------------------------------------------------------------
interface multiport_fifo_if #(
    parameter int ENTRY_WIDTH = 32,
    parameter int N_ENTRIES   = 8,
    parameter int N_ENQ       = 2,
    parameter int N_DEQ       = 2
);
    localparam int PTR_WIDTH = $clog2(N_ENTRIES);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    logic                         flush;
    logic [N_ENQ-1:0]             enq_valid;
    logic [N_ENQ-1:0]             enq_ready;
    logic [N_ENQ*ENTRY_WIDTH-1:0] enq_data;
    logic [N_DEQ-1:0]             deq_ready;
    logic [N_DEQ-1:0]             deq_valid;
    logic [N_DEQ*ENTRY_WIDTH-1:0] deq_data;
    logic [CNT_WIDTH-1:0]         count;
    logic [CNT_WIDTH-1:0]         free_cnt;

    modport master (
        output flush, enq_valid, enq_data, deq_ready,
        input  enq_ready, deq_valid, deq_data, count, free_cnt
    );

    modport slave (
        input  flush, enq_valid, enq_data, deq_ready,
        output enq_ready, deq_valid, deq_data, count, free_cnt
    );
endinterface

// File: rtl/multiport_fifo.sv
// ---------------------------------------------------------------------------
// multiport_fifo
// Purpose : Multi-lane in-order FIFO used between superscalar pipeline stages.
//           Accepts up to N_ENQ entries and returns up to N_DEQ entries per
//           cycle, with a synchronous flush for mispredict/exception recovery.
// Ports   :
//   clk    - rising-edge clock
//   rst_aL - asynchronous reset, active low; clears counters and storage
//   bus    - multiport_fifo_if slave modport (handshakes, data, occupancy)
// All bus outputs are derived from registered state only, so there is no
// combinational path from enq_valid/deq_ready to any output.
// ---------------------------------------------------------------------------
module multiport_fifo #(
    parameter int ENTRY_WIDTH = 32,
    parameter int N_ENTRIES   = 8,
    parameter int N_ENQ       = 2,
    parameter int N_DEQ       = 2
) (
    input  logic              clk,
    input  logic              rst_aL,
    multiport_fifo_if.slave   bus
);
    localparam int PTR_WIDTH = $clog2(N_ENTRIES);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(N_ENTRIES);

    // Counters carry one extra MSB so full (difference = DEPTH) and empty
    // (difference = 0) are distinguishable; low bits are the ring pointers.
    logic [CNT_WIDTH-1:0]   r_enqCtr;
    logic [CNT_WIDTH-1:0]   r_deqCtr;
    logic [ENTRY_WIDTH-1:0] r_mem [N_ENTRIES];

    logic [CNT_WIDTH-1:0]   w_count;
    logic [CNT_WIDTH-1:0]   w_free;
    logic [PTR_WIDTH-1:0]   w_enqPtr;
    logic [PTR_WIDTH-1:0]   w_deqPtr;
    logic [N_ENQ-1:0]       w_enqFire;
    logic                   w_enqRun;
    logic [CNT_WIDTH-1:0]   w_nEnq;
    logic                   w_deqRun;
    logic [CNT_WIDTH-1:0]   w_nDeq;

    assign w_count  = r_enqCtr - r_deqCtr;
    assign w_free   = DEPTH - w_count;
    assign w_enqPtr = r_enqCtr[PTR_WIDTH-1:0];
    assign w_deqPtr = r_deqCtr[PTR_WIDTH-1:0];

    assign bus.count    = w_count;
    assign bus.free_cnt = w_free;

    genvar g;
    generate
        for (g = 0; g < N_ENQ; g++) begin : g_enqReady
            assign bus.enq_ready[g] = (w_free > CNT_WIDTH'(g));
        end
        // Pointer addition in PTR_WIDTH bits gives the modulo-depth wrap.
        for (g = 0; g < N_DEQ; g++) begin : g_deqLane
            assign bus.deq_valid[g] = (w_count > CNT_WIDTH'(g));
            assign bus.deq_data[g*ENTRY_WIDTH +: ENTRY_WIDTH] =
                r_mem[w_deqPtr + PTR_WIDTH'(g)];
        end
    endgenerate

    // Accepted enqueue lanes form a contiguous prefix: the first lane that is
    // invalid or not ready stops acceptance for every younger lane.
    always_comb begin
        w_enqFire = '0;
        w_enqRun  = 1'b1;
        w_nEnq    = '0;
        for (int i = 0; i < N_ENQ; i++) begin
            w_enqRun     = w_enqRun & bus.enq_valid[i] & bus.enq_ready[i];
            w_enqFire[i] = w_enqRun;
            if (w_enqRun) begin
                w_nEnq = w_nEnq + CNT_WIDTH'(1);
            end
        end
    end

    // Dequeue lanes likewise retire as a contiguous prefix.
    always_comb begin
        w_deqRun = 1'b1;
        w_nDeq   = '0;
        for (int i = 0; i < N_DEQ; i++) begin
            w_deqRun = w_deqRun & bus.deq_ready[i] & bus.deq_valid[i];
            if (w_deqRun) begin
                w_nDeq = w_nDeq + CNT_WIDTH'(1);
            end
        end
    end

    // Flush empties the FIFO by snapping the read counter to the write
    // counter and overrides any enqueue/dequeue in the same cycle; stored
    // data is left untouched. Capacity is judged on start-of-cycle free
    // slots, so slots freed by a concurrent dequeue are not reused.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_enqCtr <= '0;
            r_deqCtr <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            r_deqCtr <= r_enqCtr;
        end else begin
            for (int i = 0; i < N_ENQ; i++) begin
                if (w_enqFire[i]) begin
                    r_mem[w_enqPtr + PTR_WIDTH'(i)] <=
                        bus.enq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
                end
            end
            r_enqCtr <= r_enqCtr + w_nEnq;
            r_deqCtr <= r_deqCtr + w_nDeq;
        end
    end

    // Occupancy can never exceed the depth; a violation means the
    // ready/valid gating above is broken.
    always @(posedge clk) begin
        if (rst_aL) begin
            assert (w_count <= DEPTH);
        end
    end
endmodule
